alu_issue_sequencer: RTL and testbench

- Issue-side initiator for the ALU controller handshake. Buffers decoded VALU instructions from the wavefront issue stage and launches one at a time.
- Launch rule: waits for ALU ready, pulses select, then holds opcode and operand/dest addresses stable until instr-done.
- On instr-done, reports a one-cycle retire event (wfid, pc) back to the issue/scoreboard logic.
- One instance per SIMD/SIMF ALU.

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_issue_fifo.sv | 68 ++++++
 rtl/alu_issue_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and widths for the ALU issue sequencer.
//   state_t : sequencer FSM encoding (IDLE/SEL/WAIT/RETIRE)
//   entry_t : one buffered VALU instruction (wfid, pc, opcode, 3 sources, 2 dests)
//   ENTRY_W : packed width of entry_t, used as the FIFO data width
package alu_issue_pkg;

    localparam int WFID_W = 6;
    localparam int PC_W   = 32;
    localparam int OP_W   = 32;
    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEL    = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    typedef struct packed {
        logic [WFID_W-1:0] wfid;
        logic [PC_W-1:0]   pc;
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] source1_addr;
        logic [ADDR_W-1:0] source2_addr;
        logic [ADDR_W-1:0] source3_addr;
        logic [ADDR_W-1:0] dest1_addr;
        logic [ADDR_W-1:0] dest2_addr;
    } entry_t;

    // Derived from the field list so the FIFO width always tracks entry_t.
    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: DEPTH x WIDTH register FIFO, synchronous active-high reset.
//   clk, rst        : clock / synchronous reset (empties the FIFO)
//   push, push_data : write request (ignored when full, even if popping)
//   pop             : read request (ignored when empty)
//   head            : entry at the read pointer (valid when !empty)
//   count           : occupancy 0..DEPTH
//   full, empty     : occupancy flags
module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: buffers decoded VALU instructions and launches them one
// at a time into an ALU controller, then reports a retire event.
//
//   state  | meaning
//   IDLE   | waiting for a buffered instruction and in_alu_ready
//   SEL    | one-cycle out_alu_select launch pulse
//   WAIT   | operands held, waiting for in_instr_done
//   RETIRE | one-cycle out_retire_valid with held wfid/pc
//
// Ports: clk/rst (sync active-high); in_issue_valid/out_issue_ready + in_*
// instruction fields (issue side); in_alu_ready/in_instr_done and
// out_alu_select/out_opcode/out_*_addr (ALU side); out_retire_* (retire);
// out_fifo_count, out_busy, out_protocol_err, out_wdog_err (status).
// Build option: ALU_ISSUE_WATCHDOG_EN enables the WAIT-state watchdog;
// without it out_wdog_err is tied low.
module alu_issue_sequencer
    import alu_issue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 3,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_issue_valid,
    output logic              out_issue_ready,
    input  logic [WFID_W-1:0] in_wfid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [ADDR_W-1:0] in_source1_addr,
    input  logic [ADDR_W-1:0] in_source2_addr,
    input  logic [ADDR_W-1:0] in_source3_addr,
    input  logic [ADDR_W-1:0] in_dest1_addr,
    input  logic [ADDR_W-1:0] in_dest2_addr,
    input  logic              in_alu_ready,
    input  logic              in_instr_done,
    output logic              out_alu_select,
    output logic [OP_W-1:0]   out_opcode,
    output logic [ADDR_W-1:0] out_source1_addr,
    output logic [ADDR_W-1:0] out_source2_addr,
    output logic [ADDR_W-1:0] out_source3_addr,
    output logic [ADDR_W-1:0] out_dest1_addr,
    output logic [ADDR_W-1:0] out_dest2_addr,
    output logic              out_retire_valid,
    output logic [WFID_W-1:0] out_retire_wfid,
    output logic [PC_W-1:0]   out_retire_pc,
    output logic [CNT_W-1:0]  out_fifo_count,
    output logic              out_busy,
    output logic              out_protocol_err,
    output logic              out_wdog_err
);

    // Elaboration-time guard on the configuration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W != $clog2(DEPTH + 1)
        || WDOG_CYCLES < 1) begin : g_bad_params
        $error("alu_issue_sequencer: illegal DEPTH/CNT_W/WDOG_CYCLES");
    end

    state_t state;
    state_t state_next;
    entry_t push_entry;
    entry_t head_entry;
    entry_t hold;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;

    assign push_entry = '{wfid:         in_wfid,
                          pc:           in_pc,
                          opcode:       in_opcode,
                          source1_addr: in_source1_addr,
                          source2_addr: in_source2_addr,
                          source3_addr: in_source3_addr,
                          dest1_addr:   in_dest1_addr,
                          dest2_addr:   in_dest2_addr};

    alu_issue_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_issue_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (out_fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_issue_ready = !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        pop              = 1'b0;
        out_alu_select   = 1'b0;
        out_retire_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && in_alu_ready) begin
                    pop        = 1'b1;
                    state_next = SEL;
                end
            end
            SEL: begin
                out_alu_select = 1'b1;
                state_next     = WAIT;
            end
            WAIT: begin
                if (in_instr_done) begin
                    state_next = RETIRE;
                end
            end
            RETIRE: begin
                out_retire_valid = 1'b1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold registers load only on the launch pop and persist after retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (pop) begin
            hold <= head_entry;
        end
    end

    assign out_opcode       = hold.opcode;
    assign out_source1_addr = hold.source1_addr;
    assign out_source2_addr = hold.source2_addr;
    assign out_source3_addr = hold.source3_addr;
    assign out_dest1_addr   = hold.dest1_addr;
    assign out_dest2_addr   = hold.dest2_addr;
    assign out_retire_wfid  = hold.wfid;
    assign out_retire_pc    = hold.pc;
    assign out_busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_protocol_err <= 1'b0;
        end else if (in_instr_done && state != WAIT) begin
            out_protocol_err <= 1'b1;
        end
    end

`ifdef ALU_ISSUE_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt;

    // Counts WAIT cycles; the flag sets on the edge the count reaches the
    // limit, and the count saturates so it cannot wrap during a long stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt     <= '0;
            out_wdog_err <= 1'b0;
        end else if (state == SEL) begin
            wdog_cnt <= '0;
        end else if (state == WAIT) begin
            if (wdog_cnt != WD_W'(WDOG_CYCLES)) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
                out_wdog_err <= 1'b1;
            end
        end
    end
`else
    assign out_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_sequencer.sv
module tb_alu_issue_sequencer;
    import alu_issue_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_issue_valid;
    logic              out_issue_ready;
    logic [WFID_W-1:0] in_wfid;
    logic [PC_W-1:0]   in_pc;
    logic [OP_W-1:0]   in_opcode;
    logic [ADDR_W-1:0] in_source1_addr;
    logic [ADDR_W-1:0] in_source2_addr;
    logic [ADDR_W-1:0] in_source3_addr;
    logic [ADDR_W-1:0] in_dest1_addr;
    logic [ADDR_W-1:0] in_dest2_addr;
    logic              in_alu_ready;
    logic              in_instr_done;
    logic              out_alu_select;
    logic [OP_W-1:0]   out_opcode;
    logic [ADDR_W-1:0] out_source1_addr;
    logic [ADDR_W-1:0] out_source2_addr;
    logic [ADDR_W-1:0] out_source3_addr;
    logic [ADDR_W-1:0] out_dest1_addr;
    logic [ADDR_W-1:0] out_dest2_addr;
    logic              out_retire_valid;
    logic [WFID_W-1:0] out_retire_wfid;
    logic [PC_W-1:0]   out_retire_pc;
    logic [2:0]        out_fifo_count;
    logic              out_busy;
    logic              out_protocol_err;
    logic              out_wdog_err;

    int checks = 0;
    int errors = 0;

    alu_issue_sequencer #(
        .DEPTH       (4),
        .CNT_W       (3),
        .WDOG_CYCLES (1024)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_issue_valid   (in_issue_valid),
        .out_issue_ready  (out_issue_ready),
        .in_wfid          (in_wfid),
        .in_pc            (in_pc),
        .in_opcode        (in_opcode),
        .in_source1_addr  (in_source1_addr),
        .in_source2_addr  (in_source2_addr),
        .in_source3_addr  (in_source3_addr),
        .in_dest1_addr    (in_dest1_addr),
        .in_dest2_addr    (in_dest2_addr),
        .in_alu_ready     (in_alu_ready),
        .in_instr_done    (in_instr_done),
        .out_alu_select   (out_alu_select),
        .out_opcode       (out_opcode),
        .out_source1_addr (out_source1_addr),
        .out_source2_addr (out_source2_addr),
        .out_source3_addr (out_source3_addr),
        .out_dest1_addr   (out_dest1_addr),
        .out_dest2_addr   (out_dest2_addr),
        .out_retire_valid (out_retire_valid),
        .out_retire_wfid  (out_retire_wfid),
        .out_retire_pc    (out_retire_pc),
        .out_fifo_count   (out_fifo_count),
        .out_busy         (out_busy),
        .out_protocol_err (out_protocol_err),
        .out_wdog_err     (out_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Source/dest addresses are base+1..base+5 so each field is distinct.
    task automatic drive_entry(input logic [5:0] w, input logic [31:0] p,
                               input logic [31:0] op, input logic [11:0] base);
        in_wfid         = w;
        in_pc           = p;
        in_opcode       = op;
        in_source1_addr = base + 12'd1;
        in_source2_addr = base + 12'd2;
        in_source3_addr = base + 12'd3;
        in_dest1_addr   = base + 12'd4;
        in_dest2_addr   = base + 12'd5;
    endtask

    initial begin
        rst            = 1'b1;
        in_issue_valid = 1'b0;
        in_alu_ready   = 1'b0;
        in_instr_done  = 1'b0;
        drive_entry(6'd0, 32'd0, 32'd0, 12'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count",    32'(out_fifo_count),   32'd0);
        chk("rst_ready",    32'(out_issue_ready),  32'd1);
        chk("rst_busy",     32'(out_busy),         32'd0);
        chk("rst_select",   32'(out_alu_select),   32'd0);
        chk("rst_retire",   32'(out_retire_valid), 32'd0);
        chk("rst_perr",     32'(out_protocol_err), 32'd0);
        chk("rst_wdog",     32'(out_wdog_err),     32'd0);
        chk("rst_opcode",   out_opcode,            32'd0);

        // Single instruction, ALU ready
        in_alu_ready   = 1'b1;
        drive_entry(6'd5, 32'h100, 32'h0100_0003, 12'h010);
        in_issue_valid = 1'b1;
        tick();
        in_issue_valid = 1'b0;
        chk("t1_count_after_push", 32'(out_fifo_count), 32'd1);
        chk("t1_no_select_yet",    32'(out_alu_select), 32'd0);
        tick();
        chk("t1_select",  32'(out_alu_select),   32'd1);
        chk("t1_count0",  32'(out_fifo_count),   32'd0);
        chk("t1_busy",    32'(out_busy),         32'd1);
        chk("t1_opcode",  out_opcode,            32'h0100_0003);
        chk("t1_src1",    32'(out_source1_addr), 32'h011);
        chk("t1_src2",    32'(out_source2_addr), 32'h012);
        chk("t1_src3",    32'(out_source3_addr), 32'h013);
        chk("t1_dst1",    32'(out_dest1_addr),   32'h014);
        chk("t1_dst2",    32'(out_dest2_addr),   32'h015);
        tick();
        chk("t1_select_pulse_end", 32'(out_alu_select), 32'd0);
        chk("t1_wait_busy",        32'(out_busy),       32'd1);
        tick();
        tick();
        tick();
        chk("t1_wait_no_retire", 32'(out_retire_valid), 32'd0);
        chk("t1_wait_opcode",    out_opcode,            32'h0100_0003);
        in_instr_done = 1'b1;
        tick();
        in_instr_done = 1'b0;
        chk("t1_retire_valid", 32'(out_retire_valid), 32'd1);
        chk("t1_retire_wfid",  32'(out_retire_wfid),  32'd5);
        chk("t1_retire_pc",    out_retire_pc,         32'h100);
        tick();
        chk("t1_retire_pulse_end", 32'(out_retire_valid), 32'd0);
        chk("t1_idle",             32'(out_busy),         32'd0);
        chk("t1_opcode_persists",  out_opcode,            32'h0100_0003);
        chk("t1_no_perr",          32'(out_protocol_err), 32'd0);

        // Fill with ALU not ready; 5th push refused while full
        in_alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_entry(6'(10 + i), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 12'(32'h100 * (i + 1)));
            in_issue_valid = 1'b1;
            tick();
        end
        drive_entry(6'd14, 32'h210, 32'hA4, 12'h500);
        chk("t2_count_full", 32'(out_fifo_count),  32'd4);
        chk("t2_ready_low",  32'(out_issue_ready), 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        chk("t2_full_holds",        32'(out_fifo_count), 32'd4);
        chk("t2_no_select_not_rdy", 32'(out_alu_select), 32'd0);
        chk("t2_idle_not_rdy",      32'(out_busy),       32'd0);
        in_alu_ready = 1'b1;
        tick();
        chk("t2_select_after_rdy",  32'(out_alu_select),  32'd1);
        chk("t2_no_bypass_count",   32'(out_fifo_count),  32'd3);
        chk("t2_ready_after_pop",   32'(out_issue_ready), 32'd1);
        chk("t2_opcode_A",          out_opcode,           32'hA0);
        chk("t2_src1_A",            32'(out_source1_addr), 32'h101);
        chk("t2_dst2_A",            32'(out_dest2_addr),  32'h105);
        tick();
        in_issue_valid = 1'b0;
        chk("t2_fifth_accepted", 32'(out_fifo_count),  32'd4);
        chk("t2_ready_low_again", 32'(out_issue_ready), 32'd0);
        chk("t2_opcode_held",    out_opcode,           32'hA0);
        tick();
        in_instr_done = 1'b1;
        tick();
        in_instr_done = 1'b0;
        in_alu_ready  = 1'b0;
        chk("t2_retire_valid", 32'(out_retire_valid), 32'd1);
        chk("t2_retire_wfid",  32'(out_retire_wfid),  32'd10);
        chk("t2_retire_pc",    out_retire_pc,         32'h200);
        tick();
        chk("t2_back_idle", 32'(out_busy),       32'd0);
        chk("t2_count_4",   32'(out_fifo_count), 32'd4);

        // instr_done while IDLE
        in_instr_done = 1'b1;
        tick();
        in_instr_done = 1'b0;
        chk("t3_perr_set",      32'(out_protocol_err), 32'd1);
        chk("t3_still_idle",    32'(out_busy),         32'd0);
        chk("t3_no_retire",     32'(out_retire_valid), 32'd0);
        chk("t3_count_intact",  32'(out_fifo_count),   32'd4);
        tick();
        chk("t3_perr_sticky",   32'(out_protocol_err), 32'd1);

        // Reset while WAIT with 3 queued
        in_alu_ready = 1'b1;
        tick();
        in_alu_ready = 1'b0;
        chk("t4_select_B",  32'(out_alu_select),   32'd1);
        chk("t4_opcode_B",  out_opcode,            32'hA1);
        chk("t4_src3_B",    32'(out_source3_addr), 32'h203);
        chk("t4_wfid_B",    32'(out_retire_wfid),  32'd11);
        tick();
        chk("t4_wait_busy", 32'(out_busy),       32'd1);
        chk("t4_count3",    32'(out_fifo_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_count",  32'(out_fifo_count),   32'd0);
        chk("t4_rst_busy",   32'(out_busy),         32'd0);
        chk("t4_rst_retire", 32'(out_retire_valid), 32'd0);
        chk("t4_rst_ready",  32'(out_issue_ready),  32'd1);
        chk("t4_rst_perr",   32'(out_protocol_err), 32'd0);
        chk("t4_rst_opcode", out_opcode,            32'd0);
        tick();
        chk("t4_no_late_retire", 32'(out_retire_valid), 32'd0);
        chk("t4_still_idle",     32'(out_busy),         32'd0);

        // Boundary field values, done on the first WAIT cycle
        in_alu_ready   = 1'b1;
        drive_entry(6'h3F, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 12'hFF0);
        in_issue_valid = 1'b1;
        tick();
        in_issue_valid = 1'b0;
        tick();
        chk("t5_select",  32'(out_alu_select),   32'd1);
        chk("t5_opcode",  out_opcode,            32'hFFFF_FFFF);
        chk("t5_dst1",    32'(out_dest1_addr),   32'hFF4);
        tick();
        in_instr_done = 1'b1;
        tick();
        in_instr_done = 1'b0;
        chk("t5_retire_valid", 32'(out_retire_valid), 32'd1);
        chk("t5_retire_wfid",  32'(out_retire_wfid),  32'h3F);
        chk("t5_retire_pc",    out_retire_pc,         32'hFFFF_FFFC);
        chk("t5_no_perr",      32'(out_protocol_err), 32'd0);
        tick();
        chk("t5_idle",   32'(out_busy),       32'd0);
        chk("t5_empty",  32'(out_fifo_count), 32'd0);
        chk("t5_wdog",   32'(out_wdog_err),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
